// File: rtl/hazard_pkg.sv
// Shared constants and FSM state encodings for the hazard scoreboard.
// Forward-select codes match the Execute operand mux encoding.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    MEM_RUN  = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks occupancy of the multi-cycle mult/div unit: busy for exactly MD_LAT
// cycles after an accepted issue, counting down even while the pipeline is frozen.
module md_busy_tracker #(
  parameter int MD_LAT   = 32,
  parameter int MD_CNT_W = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic i_accept,
  output logic o_busy
);
  import hazard_pkg::*;

  md_state_t           r_state;
  md_state_t           w_stateNext;
  logic [MD_CNT_W-1:0] r_count;
  logic [MD_CNT_W-1:0] w_countNext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= MD_IDLE;
      r_count <= '0;
    end else begin
      // A second issue while busy would corrupt HI/LO; decode stalls must prevent it.
      assert (!(i_accept && r_state == MD_BUSY));
      r_state <= w_stateNext;
      r_count <= w_countNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    case (r_state)
      MD_IDLE: begin
        if (i_accept) begin
          w_stateNext = MD_BUSY;
          w_countNext = MD_CNT_W'(MD_LAT);
        end
      end
      MD_BUSY: begin
        w_countNext = r_count - MD_CNT_W'(1);
        if (r_count == MD_CNT_W'(1)) begin
          w_stateNext = MD_IDLE;
        end
      end
      default: begin
        w_stateNext = MD_IDLE;
        w_countNext = '0;
      end
    endcase
  end

  assign o_busy = (r_state == MD_BUSY);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding, load-use/branch/HI-LO
// stalls, variable-latency memory freeze, and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int REG_W    = 5,
  parameter int MD_LAT   = 32,
  parameter int MD_CNT_W = 6,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic             BranchD,
  input  logic             HiLoD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic             MemtoRegE,
  input  logic             RegWriteE,
  input  logic             MdStartE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic             MemtoRegM,
  input  logic             RegWriteM,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteW,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushE,
  output logic             FlushW,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MdBusy,
  output logic [CNT_W-1:0] StallCount
);
  import hazard_pkg::*;

  mem_state_t       r_memState;
  mem_state_t       w_memStateNext;
  logic [CNT_W-1:0] r_stallCount;
  logic w_memWait, w_lwStall, w_brStall, w_mdStall, w_hazard, w_mdAccept, w_mdBusy;
  logic w_wrENz, w_wrMNz, w_wrWNz;

  // Register 0 is hard-wired, so a zero destination never creates a dependency.
  assign w_wrENz = (WriteRegE != '0);
  assign w_wrMNz = (WriteRegM != '0);
  assign w_wrWNz = (WriteRegW != '0);

  assign w_memWait = MemReqM && !MemReadyM;
  assign w_lwStall = MemtoRegE && w_wrENz && (RsD == WriteRegE || RtD == WriteRegE);
  assign w_brStall = BranchD &&
                     ((RegWriteE && w_wrENz && (RsD == WriteRegE || RtD == WriteRegE)) ||
                      (MemtoRegM && w_wrMNz && (RsD == WriteRegM || RtD == WriteRegM)));
  assign w_mdStall = HiLoD && (w_mdBusy || MdStartE);
  assign w_hazard  = w_lwStall || w_brStall || w_mdStall;
  assign w_mdAccept = MdStartE && !StallE;

  md_busy_tracker #(
    .MD_LAT   (MD_LAT),
    .MD_CNT_W (MD_CNT_W)
  ) u_mdBusy (
    .clk      (clk),
    .reset    (reset),
    .i_accept (w_mdAccept),
    .o_busy   (w_mdBusy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_memState   <= MEM_RUN;
      r_stallCount <= '0;
    end else begin
      r_memState <= w_memStateNext;
      if (StallD && r_stallCount != '1) begin
        r_stallCount <= r_stallCount + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_memStateNext = r_memState;
    case (r_memState)
      MEM_RUN:  if (w_memWait) w_memStateNext = MEM_WAIT;
      MEM_WAIT: if (MemReadyM) w_memStateNext = MEM_RUN;
      default:  w_memStateNext = MEM_RUN;
    endcase
  end

  // Outputs are held low during reset; a memory wait overrides every other stall.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!reset) begin
      ForwardAD = RegWriteM && w_wrMNz && (RsD == WriteRegM);
      ForwardBD = RegWriteM && w_wrMNz && (RtD == WriteRegM);
      if (RegWriteM && w_wrMNz && RsE == WriteRegM)      ForwardAE = FWD_M;
      else if (RegWriteW && w_wrWNz && RsE == WriteRegW) ForwardAE = FWD_W;
      if (RegWriteM && w_wrMNz && RtE == WriteRegM)      ForwardBE = FWD_M;
      else if (RegWriteW && w_wrWNz && RtE == WriteRegW) ForwardBE = FWD_W;
      if (w_memWait) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = w_hazard;
        StallD = w_hazard;
        FlushE = w_hazard;
      end
    end
  end

  assign MdBusy     = w_mdBusy;
  assign StallCount = r_stallCount;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the hazard rules.
module tb_hazard_scoreboard;

  localparam int REG_W    = 5;
  localparam int MD_LAT   = 4;
  localparam int MD_CNT_W = 6;
  localparam int CNT_W    = 3;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int OUT_W    = 13 + CNT_W;

  logic clk = 1'b0;
  logic reset;
  logic [REG_W-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic BranchD, HiLoD, MemtoRegE, RegWriteE, MdStartE;
  logic MemtoRegM, RegWriteM, MemReqM, MemReadyM, RegWriteW;
  logic StallF, StallD, StallE, StallM, FlushE, FlushW, ForwardAD, ForwardBD, MdBusy;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCount;

  int checks = 0;
  int errors = 0;
  int mdRem = 0;
  int stallCnt = 0;

  hazard_scoreboard #(
    .REG_W(REG_W), .MD_LAT(MD_LAT), .MD_CNT_W(MD_CNT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .BranchD(BranchD), .HiLoD(HiLoD),
    .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .MemtoRegE(MemtoRegE),
    .RegWriteE(RegWriteE), .MdStartE(MdStartE),
    .WriteRegM(WriteRegM), .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .FlushW(FlushW), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MdBusy(MdBusy), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  wire [OUT_W-1:0] dutOut = {StallF, StallD, StallE, StallM, FlushE, FlushW,
                             ForwardAD, ForwardBD, ForwardAE, ForwardBE, MdBusy, StallCount};

  // Dependency test with the register-0 exclusion applied.
  function automatic logic dep(input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst, input logic wr);
    return wr && (dst != 0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwdSel(input logic [REG_W-1:0] src);
    if (dep(src, WriteRegM, RegWriteM)) return 2'b10;
    if (dep(src, WriteRegW, RegWriteW)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [OUT_W-1:0] modelOut();
    logic memWait, lw, br, md, hz;
    logic sF, sD, sE, sM, fE, fW;
    if (reset) return '0;
    memWait = MemReqM && !MemReadyM;
    lw = dep(RsD, WriteRegE, MemtoRegE) || dep(RtD, WriteRegE, MemtoRegE);
    br = BranchD && (dep(RsD, WriteRegE, RegWriteE) || dep(RtD, WriteRegE, RegWriteE) ||
                     dep(RsD, WriteRegM, MemtoRegM) || dep(RtD, WriteRegM, MemtoRegM));
    md = HiLoD && ((mdRem > 0) || MdStartE);
    hz = lw || br || md;
    if (memWait) begin
      sF = 1; sD = 1; sE = 1; sM = 1; fE = 0; fW = 1;
    end else begin
      sF = hz; sD = hz; sE = 0; sM = 0; fE = hz; fW = 0;
    end
    return {sF, sD, sE, sM, fE, fW, dep(RsD, WriteRegM, RegWriteM), dep(RtD, WriteRegM, RegWriteM),
            fwdSel(RsE), fwdSel(RtE), (mdRem > 0), CNT_W'(stallCnt)};
  endfunction

  // Advance one clock, updating the model from the values seen before the edge.
  task automatic tick();
    logic [OUT_W-1:0] e;
    logic acc;
    e = modelOut();
    acc = MdStartE && !e[OUT_W-3] && !reset;
    @(posedge clk);
    if (reset) begin
      mdRem = 0;
      stallCnt = 0;
    end else begin
      if (acc) mdRem = MD_LAT;
      else if (mdRem > 0) mdRem--;
      if (e[OUT_W-2] && stallCnt < CNT_MAX) stallCnt++;
    end
    #1;
  endtask

  task automatic clearInputs();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    BranchD = 0; HiLoD = 0; MemtoRegE = 0; RegWriteE = 0; MdStartE = 0;
    MemtoRegM = 0; RegWriteM = 0; MemReqM = 0; MemReadyM = 0; RegWriteW = 0;
  endtask

  task automatic applyReset();
    reset = 1;
    #2;
    mdRem = 0;
    stallCnt = 0;
    reset = 0;
  endtask

  task automatic test_reset();
    clearInputs();
    MemtoRegE = 1; WriteRegE = 5'd8; RsD = 5'd8;
    RsE = 5'd9; WriteRegM = 5'd9; RegWriteM = 1;
    reset = 1;
    #1;
    mdRem = 0; stallCnt = 0;
    checks++;
    if (dutOut !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs got %h want %h", dutOut, {OUT_W{1'b0}});
    end
    reset = 0;
    #1;
    checks++;
    if (dutOut !== modelOut()) begin
      errors++; $display("[TB] FAIL reset_release got %h want %h", dutOut, modelOut());
    end
    clearInputs();
    tick();
  endtask

  task automatic test_load_use();
    clearInputs();
    applyReset();
    MemtoRegE = 1; WriteRegE = 5'd8; RsD = 5'd8;
    #2;
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b111 || dutOut !== modelOut()) begin
      errors++; $display("[TB] FAIL load_use_stall got %h want %h", dutOut, modelOut());
    end
    tick();
    MemtoRegE = 0;
    #2;
    checks++;
    if (StallCount !== CNT_W'(1) || {StallF, StallD, FlushE} !== 3'b000 || dutOut !== modelOut()) begin
      errors++; $display("[TB] FAIL load_use_release got %h want %h", dutOut, modelOut());
    end
    tick();
  endtask

  task automatic test_forward();
    clearInputs();
    RsE = 5'd9; RtE = 5'd9; WriteRegM = 5'd9; RegWriteM = 1; WriteRegW = 5'd9; RegWriteW = 1;
    #2;
    checks++;
    if (ForwardAE !== 2'b10 || ForwardBE !== 2'b10) begin
      errors++; $display("[TB] FAIL fwd_m_priority got %b/%b want 10/10", ForwardAE, ForwardBE);
    end
    RegWriteM = 0;
    #1;
    checks++;
    if (ForwardAE !== 2'b01 || dutOut !== modelOut()) begin
      errors++; $display("[TB] FAIL fwd_from_w got %b want 01", ForwardAE);
    end
    RegWriteM = 1; RsE = '0; RtE = '0; WriteRegM = '0; WriteRegW = '0;
    #1;
    checks++;
    if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin
      errors++; $display("[TB] FAIL fwd_reg_zero got %b/%b want 00/00", ForwardAE, ForwardBE);
    end
    tick();
  endtask

  task automatic test_branch();
    clearInputs();
    BranchD = 1; RtD = 5'd4; RegWriteE = 1; WriteRegE = 5'd4;
    #2;
    checks++;
    if (StallD !== 1'b1 || FlushE !== 1'b1 || dutOut !== modelOut()) begin
      errors++; $display("[TB] FAIL branch_alu_stall got %h want %h", dutOut, modelOut());
    end
    tick();
    RegWriteE = 0; WriteRegE = '0; WriteRegM = 5'd4; RegWriteM = 1; MemtoRegM = 0;
    #2;
    checks++;
    if (StallD !== 1'b0 || ForwardBD !== 1'b1 || dutOut !== modelOut()) begin
      errors++; $display("[TB] FAIL branch_forward got %h want %h", dutOut, modelOut());
    end
    MemtoRegM = 1;
    #1;
    checks++;
    if (StallD !== 1'b1 || dutOut !== modelOut()) begin
      errors++; $display("[TB] FAIL branch_load_stall got %h want %h", dutOut, modelOut());
    end
    tick();
  endtask

  task automatic test_muldiv();
    clearInputs();
    applyReset();
    MdStartE = 1;
    #2;
    checks++;
    if (MdBusy !== 1'b0 || dutOut !== modelOut()) begin
      errors++; $display("[TB] FAIL md_issue got %h want %h", dutOut, modelOut());
    end
    tick();
    MdStartE = 0; HiLoD = 1;
    for (int i = 0; i < MD_LAT; i++) begin
      #2;
      checks++;
      if (MdBusy !== 1'b1 || StallD !== 1'b1 || dutOut !== modelOut()) begin
        errors++; $display("[TB] FAIL md_busy_cycle%0d got %h want %h", i, dutOut, modelOut());
      end
      tick();
    end
    #2;
    checks++;
    if (MdBusy !== 1'b0 || StallD !== 1'b0 || dutOut !== modelOut()) begin
      errors++; $display("[TB] FAIL md_done got %h want %h", dutOut, modelOut());
    end
    tick();
  endtask

  task automatic test_mem_wait();
    clearInputs();
    applyReset();
    MdStartE = 1;
    tick();
    MdStartE = 0;
    MemReqM = 1; MemReadyM = 0; MemtoRegE = 1; WriteRegE = 5'd8; RsD = 5'd8;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if ({StallF, StallD, StallE, StallM, FlushW, FlushE} !== 6'b111110 || MdBusy !== 1'b1 ||
          dutOut !== modelOut()) begin
        errors++; $display("[TB] FAIL mem_wait_cycle%0d got %h want %h", i, dutOut, modelOut());
      end
      tick();
    end
    MemReadyM = 1; MemtoRegE = 0;
    #2;
    checks++;
    if ({StallF, StallE, StallM, FlushW} !== 4'b0000 || MdBusy !== 1'b1 || dutOut !== modelOut()) begin
      errors++; $display("[TB] FAIL mem_ready got %h want %h", dutOut, modelOut());
    end
    tick();
    MemReqM = 0;
    #2;
    checks++;
    if (MdBusy !== 1'b0 || dutOut !== modelOut()) begin
      errors++; $display("[TB] FAIL mem_md_schedule got %h want %h", dutOut, modelOut());
    end
    tick();
  endtask

  task automatic test_reset_mid();
    clearInputs();
    applyReset();
    MdStartE = 1;
    tick();
    MdStartE = 0; MemReqM = 1; MemReadyM = 0; HiLoD = 1;
    tick();
    #2;
    reset = 1;
    #1;
    mdRem = 0; stallCnt = 0;
    checks++;
    if (dutOut !== '0) begin
      errors++; $display("[TB] FAIL reset_mid_async got %h want %h", dutOut, {OUT_W{1'b0}});
    end
    #1;
    reset = 0; MemReqM = 0;
    #1;
    checks++;
    if (dutOut !== modelOut()) begin
      errors++; $display("[TB] FAIL reset_mid_release got %h want %h", dutOut, modelOut());
    end
    tick();
    MemReqM = 1; MemReadyM = 1;
    #2;
    checks++;
    if (MdBusy !== 1'b0 || StallD !== 1'b0 || dutOut !== modelOut()) begin
      errors++; $display("[TB] FAIL reset_mid_idle got %h want %h", dutOut, modelOut());
    end
    tick();
  endtask

  task automatic test_saturation();
    clearInputs();
    applyReset();
    MemtoRegE = 1; WriteRegE = 5'd8; RsD = 5'd8;
    repeat (10) tick();
    #2;
    checks++;
    if (StallCount !== CNT_W'(CNT_MAX) || dutOut !== modelOut()) begin
      errors++; $display("[TB] FAIL stall_count_saturate got %0d want %0d", StallCount, CNT_MAX);
    end
    clearInputs();
    tick();
  endtask

  task automatic test_random();
    clearInputs();
    applyReset();
    for (int i = 0; i < 400; i++) begin
      RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
      RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      BranchD = 1'($urandom); HiLoD = 1'($urandom); MemtoRegE = 1'($urandom);
      RegWriteE = 1'($urandom); MemtoRegM = 1'($urandom); RegWriteM = 1'($urandom);
      RegWriteW = 1'($urandom); MemReqM = 1'($urandom);
      MemReadyM = ($urandom_range(0, 3) != 0);
      MdStartE = (mdRem == 0) && ($urandom_range(0, 5) == 0);
      #2;
      checks++;
      if (dutOut !== modelOut()) begin
        errors++; $display("[TB] FAIL random_cycle%0d got %h want %h", i, dutOut, modelOut());
      end
      tick();
    end
    clearInputs();
    tick();
  endtask

  initial begin
    reset = 1;
    clearInputs();
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_forward();
    test_branch();
    test_muldiv();
    test_mem_wait();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised next-generation hazard controller for the 5-stage MIPS pipeline.
- Keeps the combinational forwarding and stall logic for load-use and branch hazards.
- Adds sequential tracking for two things:
  - a multi-cycle multiply/divide unit (HI/LO busy counter);
  - a variable-latency data memory (wait FSM that freezes F/D/E/M and bubbles W).
- Also keeps a saturating stall-cycle performance counter.
- Sits beside the datapath and drives every pipeline-register enable and flush.

Parameters:
- REG_W, 5, register-specifier width.
- MD_LAT, 32, cycles the mult/div unit stays busy after issue (>=1).
- MD_CNT_W, 6, width of the mult/div countdown (must hold MD_LAT).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- RsD, RtD  in  REG_W  Decode source registers.
- BranchD  in  1  Decode holds a branch.
- HiLoD  in  1  Decode instruction reads or writes HI/LO (mult/div/mfhi/mflo/mthi/mtlo).
- RsE, RtE  in  REG_W  Execute source registers.
- WriteRegE  in  REG_W  Execute destination register.
- MemtoRegE, RegWriteE  in  1  Execute control.
- MdStartE  in  1  Execute issues a mult/div this cycle.
- WriteRegM  in  REG_W  Mem destination register.
- MemtoRegM, RegWriteM  in  1  Mem control.
- MemReqM  in  1  Mem stage performs a load or store.
- MemReadyM  in  1  memory acknowledges the access this cycle.
- WriteRegW  in  REG_W  Writeback destination register.
- RegWriteW  in  1  Writeback control.
- StallF, StallD, StallE, StallM  out  1  active-high hold of the pipeline register feeding that stage.
- FlushE  out  1  bubble into Execute.
- FlushW  out  1  bubble into Writeback.
- ForwardAD, ForwardBD  out  1  forward the ALU result from M to the Decode comparator.
- ForwardAE, ForwardBE  out  2  Execute operand select: 10 = from M, 01 = from W, 00 = register file.
- MdBusy  out  1  mult/div unit is occupied.
- StallCount  out  CNT_W  cycles in which StallD was high.

Behaviour:
- Reset (asynchronous, active-high):
  - every output is 0;
  - memory FSM returns to RUN;
  - mult/div FSM returns to IDLE with the countdown at 0;
  - StallCount is 0;
  - reset mid-operation abandons the mult/div countdown and any memory wait immediately.
- Register 0 never matches in any comparison below.
- Forwarding (combinational):
  - ForwardAE = 10 if RsE==WriteRegM && RegWriteM;
  - else 01 if RsE==WriteRegW && RegWriteW;
  - else 00;
  - ForwardBE is the same using RtE; M has priority over W;
  - ForwardAD = RsD==WriteRegM && RegWriteM;
  - ForwardBD = RtD==WriteRegM && RegWriteM.
- lwStall = MemtoRegE && (RsD==WriteRegE || RtD==WriteRegE).
- brStall = BranchD && ((RegWriteE && WriteRegE in {RsD,RtD}) || (MemtoRegM && WriteRegM in {RsD,RtD})).
- mdStall = HiLoD && (MdBusy || MdStartE).
- Memory FSM, states RUN and WAIT:
  - memWait = MemReqM && !MemReadyM;
  - RUN -> WAIT when memWait;
  - WAIT -> RUN on the first cycle MemReadyM is high;
  - while memWait is high (combinational, including the first cycle):
    - StallF = StallD = StallE = StallM = 1;
    - FlushW = 1;
    - FlushE = 0;
    - all other stalls are masked.
- Otherwise (no memory wait):
  - StallF = StallD = lwStall || brStall || mdStall;
  - FlushE = the same value;
  - StallE = StallM = FlushW = 0.
- Mult/div FSM, states IDLE and BUSY:
  - MdStartE is accepted only when StallE==0;
  - on acceptance: count <= MD_LAT, state BUSY, and MdBusy rises the next cycle;
  - in BUSY, count decrements every cycle, including during memory freezes;
  - at count==1: next state IDLE, MdBusy falls;
  - total MdBusy high time is exactly MD_LAT cycles;
  - MdStartE while BUSY is a protocol violation, prevented by mdStall; the RTL asserts on it in simulation;
  - MD_LAT==1 yields a single busy cycle.
- StallCount increments each cycle StallD==1 and saturates at all ones (no wrap).

Decomposition:
- Shared package hazard_pkg holds:
  - the forward-select constants FWD_RF=00, FWD_W=01, FWD_M=10;
  - the memory-FSM and mult/div-FSM state encodings.
- One natural sub-module, md_busy_tracker, holds the mult/div FSM and countdown. It outputs MdBusy and takes the accept strobe.
- All other logic stays in the top level.

Test Plan:
- Load-use: MemtoRegE=1, WriteRegE=8, RsD=8 -> StallF=StallD=FlushE=1 for one cycle, StallCount=1; the next cycle with MemtoRegE=0 shows all stalls at 0.
- Forward priority: RsE=9, WriteRegM=9, RegWriteM=1, WriteRegW=9, RegWriteW=1 -> ForwardAE=10; with RsE=0 and the same writes -> ForwardAE=00.
- Branch: BranchD=1, RtD=4, RegWriteE=1, WriteRegE=4 -> StallD=FlushE=1; next cycle WriteRegM=4, RegWriteM=1, MemtoRegM=0 -> stall 0, ForwardBD=1.
- Mult/div: MD_LAT=4, MdStartE pulse -> MdBusy high for exactly 4 cycles; HiLoD=1 during those cycles -> StallD=1; HiLoD=1 on the cycle MdBusy falls -> no stall.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> StallF/D/E/M and FlushW high for 3 cycles, FlushE=0, and a concurrent lwStall is masked; a concurrent MD_LAT=4 countdown still ends on schedule.
- Reset and saturation: assert reset during BUSY and WAIT -> all outputs 0 asynchronously; with CNT_W=3, hold lwStall for 10 cycles -> StallCount stops at 7.
